scoreboard: RTL and testbench

- Consumer-side counterpart of the execute-to-rfetch forwarding path.
- Forwarding covers single-cycle producers. This block tracks destination registers of long-latency ops in flight (loads, mul/div) that cannot be forwarded.
- It stalls the rfetch stage until each such register is written back.
- Sits beside rfetch. It consumes rfetch operand fields and the writeback port, and drives the rfetch stall.

---
 rtl/scoreboard.sv | 137 +++++++++++++
 tb/tb_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard.sv
// Long-latency register scoreboard: tracks in-flight load/mul/div destinations and stalls rfetch.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a register being written back this cycle stop stalling.
module scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_W           = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_W     = 16,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rfetch_v_i,
  input  logic [REG_W-1:0]       rfetch_rs1_i,
  input  logic                   rfetch_rs1_v_i,
  input  logic [REG_W-1:0]       rfetch_rs2_i,
  input  logic                   rfetch_rs2_v_i,
  input  logic [REG_W-1:0]       rfetch_rd_i,
  input  logic                   rfetch_rd_w_v_i,
  input  logic                   rfetch_long_v_i,
  input  logic                   execute_ready_i,
  input  logic                   wb_v_i,
  input  logic [REG_W-1:0]       wb_rd_i,
  output logic                   scoreboard_stall_o,
  output logic                   issue_v_o,
  output logic [NUM_REGS-1:0]    pending_o,
  output logic [OUT_W-1:0]       outstanding_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o,
  output logic                   scoreboard_err_o
);

  localparam logic [OUT_W-1:0]       OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [STALL_CNT_W-1:0] STALL_SAT = '1;

  logic [NUM_REGS-1:0]    pending_q, pending_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   err_q, err_d;

  logic [NUM_REGS-1:0] eff_pend;
  logic [NUM_REGS-1:0] wb_onehot;
  logic                raw1, raw2, waw, full;
  logic                stall, issue;
  logic                set_pend, inc_out, dec_out;

  always_comb begin
    wb_onehot          = '0;
    wb_onehot[wb_rd_i] = wb_v_i;
  end

  // Bypass relies on a write-through regfile: the writeback value is readable the same cycle.
`ifdef SCOREBOARD_WB_BYPASS_EN
  always_comb begin
    eff_pend    = pending_q & ~wb_onehot;
    eff_pend[0] = 1'b0;
  end
`else
  always_comb begin
    eff_pend    = pending_q;
    eff_pend[0] = 1'b0;
  end
`endif

  always_comb begin
    raw1  = rfetch_rs1_v_i  && (rfetch_rs1_i != '0) && eff_pend[rfetch_rs1_i];
    raw2  = rfetch_rs2_v_i  && (rfetch_rs2_i != '0) && eff_pend[rfetch_rs2_i];
    waw   = rfetch_rd_w_v_i && (rfetch_rd_i  != '0) && eff_pend[rfetch_rd_i];
    full  = rfetch_long_v_i && (outstanding_q == OUT_MAX);
    stall = rfetch_v_i && (raw1 || raw2 || waw || full);
    issue = rfetch_v_i && !stall && execute_ready_i;
  end

  always_comb begin
    set_pend = issue && rfetch_long_v_i && rfetch_rd_w_v_i && (rfetch_rd_i != '0);
    inc_out  = issue && rfetch_long_v_i;
  end

  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    dec_out   = 1'b0;
    if (wb_v_i) begin
      if (outstanding_q == '0) begin
        err_d = 1'b1;
      end else if (wb_rd_i == '0) begin
        dec_out = 1'b1;
      end else if (pending_q[wb_rd_i]) begin
        pending_d[wb_rd_i] = 1'b0;
        dec_out            = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // A new set on the same register must survive a simultaneous clear.
    if (set_pend) begin
      pending_d[rfetch_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (inc_out && !dec_out) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!inc_out && dec_out) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != STALL_SAT)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      outstanding_q  <= '0;
      stall_cycles_q <= '0;
      err_q          <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      stall_cycles_q <= stall_cycles_d;
      err_q          <= err_d;
    end
  end

  assign scoreboard_stall_o = stall;
  assign issue_v_o          = issue;
  assign pending_o          = pending_q;
  assign outstanding_o      = outstanding_q;
  assign stall_cycles_o     = stall_cycles_q;
  assign scoreboard_err_o   = err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard; expectations follow SCOREBOARD_WB_BYPASS_EN when defined.
module tb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rfetch_v, rs1_v, rs2_v, rd_w_v, long_v, exe_rdy, wb_v;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        stall, issue, err;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic [15:0] stall_cycles;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  scoreboard dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rfetch_v_i         (rfetch_v),
    .rfetch_rs1_i       (rs1),
    .rfetch_rs1_v_i     (rs1_v),
    .rfetch_rs2_i       (rs2),
    .rfetch_rs2_v_i     (rs2_v),
    .rfetch_rd_i        (rd),
    .rfetch_rd_w_v_i    (rd_w_v),
    .rfetch_long_v_i    (long_v),
    .execute_ready_i    (exe_rdy),
    .wb_v_i             (wb_v),
    .wb_rd_i            (wb_rd),
    .scoreboard_stall_o (stall),
    .issue_v_o          (issue),
    .pending_o          (pending),
    .outstanding_o      (outstanding),
    .stall_cycles_o     (stall_cycles),
    .scoreboard_err_o   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rfetch_v = 0; rs1_v = 0; rs2_v = 0; rd_w_v = 0; long_v = 0;
    exe_rdy = 1; wb_v = 0; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
  endtask

  // Advance one edge; inputs are then changed 1ns after it and checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic long_op(input logic [4:0] r, input logic w);
    idle(); rfetch_v = 1; long_v = 1; rd = r; rd_w_v = w;
  endtask

  task automatic wb(input logic [4:0] r);
    idle(); wb_v = 1; wb_rd = r;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_pending", pending, 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_stallcnt", 32'(stall_cycles), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1;
    tick();

    // RAW on a long-latency destination
    long_op(5, 1); #1;
    chk("t1_issue_long", 32'(issue), 1);
    tick();
    chk("t1_pend5", pending, 32'h20);
    for (int c = 1; c <= 3; c++) begin
      idle(); rfetch_v = 1; rs1 = 5; rs1_v = 1; #1;
      chk("t1_raw_stall", 32'(stall), 1);
      chk("t1_raw_noissue", 32'(issue), 0);
      tick();
    end
    idle(); rfetch_v = 1; rs1 = 5; rs1_v = 1; wb_v = 1; wb_rd = 5; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t1_wb_bypass_issue", 32'(issue), 1);
    tick();
`else
    chk("t1_wb_stall", 32'(stall), 1);
    tick();
    idle(); rfetch_v = 1; rs1 = 5; rs1_v = 1; #1;
    chk("t1_issue_after_wb", 32'(issue), 1);
    tick();
`endif
    idle(); #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t1_stallcnt", 32'(stall_cycles), 3);
`else
    chk("t1_stallcnt", 32'(stall_cycles), 4);
`endif
    chk("t1_pend", pending, 0);
    chk("t1_out", 32'(outstanding), 0);

    // FULL stall at MAX_OUTSTANDING
    for (int r = 1; r <= 4; r++) begin
      long_op(5'(r), 1); #1;
      chk("t2_issue", 32'(issue), 1);
      tick();
    end
    chk("t2_out4", 32'(outstanding), 4);
    chk("t2_pend", pending, 32'h1E);
    long_op(6, 1); #1;
    chk("t2_full_stall", 32'(stall), 1);
    tick();
    long_op(6, 1); wb_v = 1; wb_rd = 1; #1;
    chk("t2_full_during_wb", 32'(stall), 1);
    tick();
    chk("t2_out3", 32'(outstanding), 3);
    long_op(6, 1); #1;
    chk("t2_fifth_issue", 32'(issue), 1);
    tick();
    chk("t2_out4b", 32'(outstanding), 4);
    chk("t2_pend2", pending, 32'h5C);
    wb(2); tick(); wb(3); tick(); wb(4); tick(); wb(6); tick();
    idle(); #1;
    chk("t2_drained_out", 32'(outstanding), 0);
    chk("t2_drained_pend", pending, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t2_stallcnt", 32'(stall_cycles), 5);
`else
    chk("t2_stallcnt", 32'(stall_cycles), 6);
`endif

    // Long op to x0
    long_op(0, 1); #1;
    chk("t3_issue", 32'(issue), 1);
    tick();
    chk("t3_pend", pending, 0);
    chk("t3_out", 32'(outstanding), 1);
    idle(); rfetch_v = 1; rs1 = 0; rs1_v = 1; #1;
    chk("t3_x0_nostall", 32'(stall), 0);
    tick();
    wb(0); tick();
    idle(); #1;
    chk("t3_out0", 32'(outstanding), 0);
    chk("t3_err", 32'(err), 0);

    // WAW on r7
    long_op(7, 1); tick();
    long_op(7, 1); #1;
    chk("t4_waw_stall", 32'(stall), 1);
    tick();
    long_op(7, 1); wb_v = 1; wb_rd = 7; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t4_bypass_issue", 32'(issue), 1);
    tick();
`else
    chk("t4_wb_stall", 32'(stall), 1);
    tick();
    long_op(7, 1); #1;
    chk("t4_issue", 32'(issue), 1);
    tick();
`endif
    idle(); #1;
    chk("t4_pend7", pending, 32'h80);
    chk("t4_out1", 32'(outstanding), 1);
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("t4_stallcnt", 32'(stall_cycles), 6);
`else
    chk("t4_stallcnt", 32'(stall_cycles), 8);
`endif
    wb(7); tick();

    // Spurious writeback to r9
    long_op(3, 1); tick();
    wb(9); tick();
    idle(); #1;
    chk("t5_err", 32'(err), 1);
    chk("t5_pend", pending, 32'h08);
    chk("t5_out", 32'(outstanding), 1);
    tick();
    chk("t5_err_sticky", 32'(err), 1);
    wb(3); tick();

    // Async reset mid-stall
    long_op(5, 1); tick();
    long_op(7, 1); tick();
    idle(); #1;
    chk("t6_pend", pending, 32'hA0);
    chk("t6_out", 32'(outstanding), 2);
    rs1 = 7; rs1_v = 1; #1;
    chk("t6_nov_nostall", 32'(stall), 0);
    rfetch_v = 1; #1;
    chk("t6_stall", 32'(stall), 1);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_out", 32'(outstanding), 0);
    chk("t6_rst_stallcnt", 32'(stall_cycles), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_stall", 32'(stall), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
